// File: rtl/vga_pkg.sv
// Shared definitions for the VGA burst fetcher: fetch FSM encoding, elaboration
// helpers and the default frame-buffer base address.
package vga_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_READ,
    S_DONE
  } fetch_state_t;

  localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_1050;

  // Ceiling log2 for parameter math; clog2(1) = 0.
  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/d_reg_sync.sv
// Enabled D register with synchronous active-high reset to a fixed value.
module d_reg_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset)   q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/vga_burst_fetch.sv
// Double-buffered line fetcher: whenever the display enters a new block it
// swaps buffers and bursts the following block from memory into the idle one.
module vga_burst_fetch
  import vga_pkg::*;
#(
  parameter int          RES_X        = 640,
  parameter int          RES_Y        = 480,
  parameter logic [31:0] BASE_ADDR    = BASE_ADDR_DEF,
  parameter int          PIX_PER_WORD = 16,
  parameter int          BURST_LEN    = 4,
  localparam int         BEAT_W       = max_int(1, clog2(BURST_LEN))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       row,
  input  logic [10:0]       col,
  input  logic              vga_output_valid,
  input  logic              bus_ack,
  input  logic              bus_wait,
  output logic              bus_req,
  output logic [31:0]       bus_addr,
  output logic              buf_sel,
  output logic              buf0_we,
  output logic              buf1_we,
  output logic [BEAT_W-1:0] buf_waddr,
  output logic              underrun,
  output logic              busy
);

  localparam int BLK_PIX = PIX_PER_WORD * BURST_LEN;
  localparam int NUM_BLK = RES_X * RES_Y / BLK_PIX;
  localparam int FRAME_W = clog2(RES_X * RES_Y);
  localparam int BLK_SH  = clog2(BLK_PIX);

  localparam logic [FRAME_W-1:0] LAST_BLK = FRAME_W'(NUM_BLK - 1);

  fetch_state_t      state;
  logic [BEAT_W-1:0] beat;
  logic              wbuf;
  logic              pending;

  logic [FRAME_W-1:0] pix_idx;
  logic [FRAME_W-1:0] disp_blk;
  logic [FRAME_W-1:0] last_blk;
  logic [FRAME_W-1:0] tgt_blk;
  logic [FRAME_W-1:0] tgt_next;
  logic [FRAME_W-1:0] tgt_d;
  logic [31:0]        tgt_addr;
  logic               blk_chg;
  logic               wr_beat;

  // Full-width product first; only in-range pixel indices are ever used.
  assign pix_idx  = FRAME_W'(32'(row) * 32'(RES_X) + 32'(col));
  assign disp_blk = pix_idx >> BLK_SH;
  assign blk_chg  = vga_output_valid && (disp_blk != last_blk);

  assign tgt_next = (disp_blk == LAST_BLK) ? '0 : disp_blk + FRAME_W'(1);
  assign tgt_d    = blk_chg ? tgt_next : tgt_blk;
  assign tgt_addr = BASE_ADDR + 32'(tgt_d) * 32'(BURST_LEN);

  d_reg_sync #(.WIDTH(1), .RST_VAL(1'b1)) u_buf_sel (
    .clk   (clk),
    .reset (reset),
    .en    (blk_chg),
    .d     (~buf_sel),
    .q     (buf_sel)
  );

  d_reg_sync #(.WIDTH(FRAME_W), .RST_VAL(LAST_BLK)) u_last_blk (
    .clk   (clk),
    .reset (reset),
    .en    (blk_chg),
    .d     (disp_blk),
    .q     (last_blk)
  );

  d_reg_sync #(.WIDTH(FRAME_W), .RST_VAL('0)) u_tgt_blk (
    .clk   (clk),
    .reset (reset),
    .en    (blk_chg),
    .d     (tgt_next),
    .q     (tgt_blk)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      beat     <= '0;
      wbuf     <= 1'b0;
      pending  <= 1'b1;
      underrun <= 1'b0;
      bus_addr <= BASE_ADDR;
    end else begin
      if (blk_chg)              pending <= 1'b1;
      else if (state == S_ADDR) pending <= 1'b0;

      // A change that finds the previous target still unserved or in flight
      // means the display has caught up with the fetcher.
      if (blk_chg && (state != S_IDLE || pending)) underrun <= 1'b1;

      // Address tracks the target only while idle, so it is frozen for the burst.
      if (state == S_IDLE) bus_addr <= tgt_addr;

      case (state)
        S_IDLE: if (bus_ack && pending) state <= S_ADDR;
        S_ADDR: begin
          wbuf  <= ~buf_sel;
          state <= S_WAIT;
        end
        S_WAIT: if (!bus_wait) begin
          beat  <= '0;
          state <= S_READ;
        end
        S_READ: if (!bus_wait) begin
          beat <= beat + BEAT_W'(1);
          if (beat == BEAT_W'(BURST_LEN - 1)) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from state so a beat is written in the cycle bus_wait drops.
  assign wr_beat   = !reset && (state == S_READ) && !bus_wait;
  assign buf0_we   = wr_beat && !wbuf;
  assign buf1_we   = wr_beat && wbuf;
  assign buf_waddr = beat;
  assign bus_req   = !reset && (state == S_IDLE) && pending;
  assign busy      = !reset && (state != S_IDLE);

endmodule

// File: tb/tb_vga_burst_fetch.sv
// Directed bench for vga_burst_fetch: default build plus BURST_LEN 1 and 16
// builds driven by the same stimulus.
module tb_vga_burst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] row, col;
  logic        vga_output_valid, bus_ack, bus_wait;

  logic        bus_req, buf_sel, buf0_we, buf1_we, underrun, busy;
  logic [31:0] bus_addr;
  logic [1:0]  buf_waddr;

  logic        a_req, a_sel, a_we0, a_we1, a_under, a_busy;
  logic [31:0] a_addr;
  logic [0:0]  a_waddr;

  logic        b_req, b_sel, b_we0, b_we1, b_under, b_busy;
  logic [31:0] b_addr;
  logic [3:0]  b_waddr;

  int checks = 0;
  int failures = 0;

  int cnt0, cnt1, stall_we, beat_err, exp_b;
  int a_cnt, b_cnt, b_err, b_exp;
  int both_we = 0;
  int req_busy = 0;

  always #5 clk = ~clk;

  vga_burst_fetch dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .vga_output_valid(vga_output_valid), .bus_ack(bus_ack), .bus_wait(bus_wait),
    .bus_req(bus_req), .bus_addr(bus_addr), .buf_sel(buf_sel),
    .buf0_we(buf0_we), .buf1_we(buf1_we), .buf_waddr(buf_waddr),
    .underrun(underrun), .busy(busy)
  );

  vga_burst_fetch #(.BURST_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .vga_output_valid(vga_output_valid), .bus_ack(bus_ack), .bus_wait(bus_wait),
    .bus_req(a_req), .bus_addr(a_addr), .buf_sel(a_sel),
    .buf0_we(a_we0), .buf1_we(a_we1), .buf_waddr(a_waddr),
    .underrun(a_under), .busy(a_busy)
  );

  vga_burst_fetch #(.BURST_LEN(16)) dut16 (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .vga_output_valid(vga_output_valid), .bus_ack(bus_ack), .bus_wait(bus_wait),
    .bus_req(b_req), .bus_addr(b_addr), .buf_sel(b_sel),
    .buf0_we(b_we0), .buf1_we(b_we1), .buf_waddr(b_waddr),
    .underrun(b_under), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr();
    cnt0 = 0; cnt1 = 0; stall_we = 0; beat_err = 0; exp_b = 0;
    a_cnt = 0; b_cnt = 0; b_err = 0; b_exp = 0;
  endtask

  // Accounts for the strobes visible in the current cycle.
  task automatic sample();
    if (buf0_we || buf1_we) begin
      if (buf_waddr != 2'(exp_b)) beat_err++;
      exp_b = (exp_b + 1) % 4;
      if (bus_wait) stall_we++;
    end
    if (buf0_we) cnt0++;
    if (buf1_we) cnt1++;
    if (buf0_we && buf1_we) both_we++;
    if (bus_req && busy) req_busy++;
    if (a_we0 || a_we1) a_cnt++;
    if (b_we0 || b_we1) begin
      b_cnt++;
      if (b_waddr != 4'(b_exp)) b_err++;
      b_exp = (b_exp + 1) % 16;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic w);
    bus_wait = w;
    #1;
    sample();
    tick();
  endtask

  initial begin
    reset = 1'b1; row = '0; col = '0;
    vga_output_valid = 1'b0; bus_ack = 1'b0; bus_wait = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_buf_sel", 32'(buf_sel), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_we", {30'd0, buf1_we, buf0_we}, 32'd0);

    // Block 0 preload into buffer 0 for all three builds.
    reset = 1'b0; bus_ack = 1'b1;
    #1;
    check("preload_req", 32'(bus_req), 32'd1);
    check("preload_addr", bus_addr, 32'h1050);
    check("preload_addr_b1", a_addr, 32'h1050);
    check("preload_addr_b16", b_addr, 32'h1050);
    clr();
    repeat (30) cyc(1'b0);
    check("preload_buf0_pulses", cnt0, 4);
    check("preload_buf1_pulses", cnt1, 0);
    check("preload_waddr", beat_err, 0);
    check("b1_pulses", a_cnt, 1);
    check("b16_pulses", b_cnt, 16);
    check("b16_waddr", b_err, 0);
    check("preload_idle", {29'd0, busy, a_busy, b_busy}, 32'd0);
    check("preload_req_clear", 32'(bus_req), 32'd0);

    // Display enters block 0: swap, fetch block 1 into buffer 1.
    vga_output_valid = 1'b1; row = 11'd0; col = 11'd0;
    tick();
    check("blk0_buf_sel", 32'(buf_sel), 32'd0);
    check("blk0_req", 32'(bus_req), 32'd1);
    check("blk0_addr", bus_addr, 32'h1054);
    check("blk0_addr_b1", a_addr, 32'h1051);
    check("blk0_addr_b16", b_addr, 32'h1060);
    clr();
    repeat (12) cyc(1'b0);
    check("blk0_buf1_pulses", cnt1, 4);
    check("blk0_buf0_pulses", cnt0, 0);
    check("blk0_waddr", beat_err, 0);

    col = 11'd64;
    tick();
    check("blk1_buf_sel", 32'(buf_sel), 32'd1);
    check("blk1_addr", bus_addr, 32'h1058);
    clr();
    repeat (12) cyc(1'b0);
    check("blk1_buf0_pulses", cnt0, 4);
    check("blk1_buf1_pulses", cnt1, 0);

    // Last block of the frame: target wraps to block 0.
    row = 11'd479; col = 11'd576;
    tick();
    check("wrap_buf_sel", 32'(buf_sel), 32'd0);
    check("wrap_addr", bus_addr, 32'h1050);
    check("wrap_addr_b16", b_addr, 32'h1050);
    check("nowrap_addr_b1", a_addr, 32'h5B4D);
    clr();
    repeat (12) cyc(1'b0);
    check("wrap_buf1_pulses", cnt1, 4);

    // Stalls: 3 cycles in WAIT, one during beat 2.
    row = 11'd0; col = 11'd0;
    tick();
    check("stall_buf_sel", 32'(buf_sel), 32'd1);
    check("stall_addr", bus_addr, 32'h1054);
    clr();
    repeat (5) cyc(1'b1);
    check("stall_wait_busy", 32'(busy), 32'd1);
    check("stall_wait_req", 32'(bus_req), 32'd0);
    check("stall_wait_nowe", cnt0 + cnt1, 0);
    repeat (3) cyc(1'b0);
    cyc(1'b1);
    repeat (4) cyc(1'b0);
    check("stall_buf0_pulses", cnt0, 4);
    check("stall_buf1_pulses", cnt1, 0);
    check("stall_we_in_stall", stall_we, 0);
    check("stall_waddr", beat_err, 0);
    check("stall_idle", 32'(busy), 32'd0);
    check("stall_no_underrun", 32'(underrun), 32'd0);

    // No grant while the display runs ahead: underrun is sticky.
    bus_ack = 1'b0; col = 11'd64;
    tick();
    check("ovr_first_change", 32'(underrun), 32'd0);
    check("ovr_req", 32'(bus_req), 32'd1);
    col = 11'd128;
    tick();
    check("ovr_underrun", 32'(underrun), 32'd1);
    check("ovr_addr", bus_addr, 32'h105C);
    repeat (3) tick();
    check("ovr_sticky", 32'(underrun), 32'd1);
    check("ovr_no_grant", 32'(busy), 32'd0);
    bus_ack = 1'b1;
    clr();
    repeat (12) cyc(1'b0);
    check("ovr_buf0_pulses", cnt0, 4);
    check("ovr_waddr", beat_err, 0);
    check("ovr_still_sticky", 32'(underrun), 32'd1);

    // Reset in the middle of a burst into buffer 1.
    col = 11'd192;
    tick();
    clr();
    repeat (4) cyc(1'b0);
    check("mid_first_beat", cnt1, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_we", {30'd0, buf1_we, buf0_we}, 32'd0);
    tick();
    check("mid_rst_we_next", {30'd0, buf1_we, buf0_we}, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_buf_sel", 32'(buf_sel), 32'd1);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    vga_output_valid = 1'b0; reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'd1);
    check("mid_rst_addr", bus_addr, 32'h1050);
    clr();
    repeat (12) cyc(1'b0);
    check("mid_rst_buf0_pulses", cnt0, 4);
    check("mid_rst_buf1_pulses", cnt1, 0);
    check("mid_rst_waddr", beat_err, 0);

    check("never_both_we", both_we, 0);
    check("never_req_busy", req_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_burst_fetch.md
VGA_BURST_FETCH -- requirements
Module: vga_burst_fetch

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- RES_X, 640, active pixels per line.
- RES_Y, 480, active lines.
- BASE_ADDR, 32'h00001050, word address of pixel 0.
- PIX_PER_WORD, 16, pixels per bus word; power of 2.
- BURST_LEN, 4, words per fetch; power of 2, 1..16.
REQ-002 Derived constants SHALL be:
- BLK_PIX = PIX_PER_WORD*BURST_LEN.
- NUM_BLK = RES_X*RES_Y/BLK_PIX; integer by construction.
- FRAME_W = clog2(RES_X*RES_Y).
- BEAT_W = max(1, clog2(BURST_LEN)).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock; everything on posedge.
- reset, in, 1, synchronous active-high reset.
- row, in, 11, current display line.
- col, in, 11, current display pixel.
- vga_output_valid, in, 1, row/col are in the active area.
- bus_ack, in, 1, bus grant.
- bus_wait, in, 1, memory not ready / beat stall.
- bus_req, out, 1, bus request.
- bus_addr, out, 32, burst start word address.
- buf_sel, out, 1, buffer the display reads.
- buf0_we, out, 1, write enable for buffer 0.
- buf1_we, out, 1, write enable for buffer 1.
- buf_waddr, out, BEAT_W, beat index inside the buffer.
- underrun, out, 1, sticky display-overtook-fetch flag.
- busy, out, 1, fetch in progress (state != IDLE).

Function
REQ-004 disp_blk SHALL equal (row*RES_X+col) >> clog2(BLK_PIX), computed at FRAME_W bits, no truncation before the shift.
REQ-005 last_blk (register) SHALL update on a block change; block change = vga_output_valid && disp_blk != last_blk.
REQ-006 On a block change, the next edge SHALL:
- load last_blk <= disp_blk;
- toggle buf_sel;
- set pending;
- load tgt_blk <= disp_blk+1, wrapping to 0 when disp_blk == NUM_BLK-1.
REQ-007 bus_addr SHALL equal BASE_ADDR + tgt_blk*BURST_LEN in 32-bit unsigned arithmetic, registered, stable from the request through DONE.
REQ-008 FSM states SHALL be IDLE, ADDR, WAIT, READ, DONE.
REQ-009 IDLE: bus_req = pending; bus_ack && pending -> ADDR; otherwise stay.
REQ-010 ADDR: one cycle; latch wbuf <= ~buf_sel; clear pending unless a block change occurs the same cycle; -> WAIT.
REQ-011 WAIT: bus_wait -> stay; else -> READ with beat = 0.
REQ-012 READ: each cycle with bus_wait low:
- assert we of buffer wbuf only (buf0_we when wbuf = 0, buf1_we when wbuf = 1);
- buf_waddr = beat;
- beat increments; -> DONE after beat BURST_LEN-1.
REQ-013 READ with bus_wait high SHALL hold beat and deassert both we.
REQ-014 DONE: one cycle, no we; -> IDLE.
REQ-015 A block change while busy SHALL set underrun (held until reset), re-arm pending with the new tgt_blk, and SHALL NOT abort the in-flight burst, which finishes into its latched wbuf.
REQ-016 buf0_we and buf1_we SHALL never be high together; bus_req SHALL be low outside IDLE.
REQ-017 A block change while vga_output_valid is low SHALL NOT occur; row/col outside the active area SHALL be ignored.

Reset
REQ-018 reset high at any edge, including mid-burst, SHALL set all of the following on the next edge:
- state IDLE; beat 0;
- buf_sel 1; wbuf 0; last_blk NUM_BLK-1;
- tgt_blk 0; pending 1 (block 0 preloads into buffer 0);
- underrun 0;
- bus_req 0, both we 0, busy 0 while reset is high.

Structure
REQ-019 Package vga_pkg SHALL hold the FSM state encoding, the clog2/max helper functions and the BASE_ADDR default.
REQ-020 Registers buf_sel, last_blk and tgt_blk SHALL use the existing d_reg_sync sub-module; no other sub-module.

Verification
REQ-021 Defaults:
- release reset, hold bus_ack = 1, bus_wait = 0;
- required: bus_addr = 0x1050;
- required: buf0_we high for 4 cycles with buf_waddr 0,1,2,3;
- required: buf1_we never high.
REQ-022 vga_output_valid = 1, row 0, col 0 -> buf_sel becomes 0; next fetch bus_addr = 0x1054 into buf1; col 64 -> buf_sel 1, bus_addr 0x1058.
REQ-023 row 479, col 576 (block 4799) -> tgt_blk wraps to 0; bus_addr = 0x1050.
REQ-024 Hold bus_wait high 3 cycles in WAIT, then one cycle during READ beat 2 -> no we during stalls; exactly 4 write pulses; waddr has no gaps.
REQ-025 Hold bus_ack low; move col 0 -> 64 -> 128 -> underrun = 1 and stays 1; after ack, the burst completes; assert reset mid-READ -> we drops on the next cycle and state restarts with the block 0 preload.
REQ-026 Parameter sweep BURST_LEN = 1 and 16 -> 1 and 16 beats per burst; address step 1 and 16.
